// File: rtl/draw_bullet_if.sv
// Pixel-stream bundle for the VGA overlay pipeline.
// Carries the raster timing and colour of one pixel per clock.
interface draw_bullet_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        h_sync;
  logic        v_sync;
  logic        h_blank;
  logic        v_blank;
  logic [11:0] rgb;

  modport master (
    output hcount, vcount,
    output h_sync, v_sync,
    output h_blank, v_blank,
    output rgb
  );

  modport slave (
    input hcount, vcount,
    input h_sync, v_sync,
    input h_blank, v_blank,
    input rgb
  );
endinterface

// File: rtl/draw_bullet.sv
// Bullet overlay and hit detection for the 800x600 game pipeline.
// Two-stage pixel path; bullet state is frozen once per frame.
module draw_bullet #(
  parameter int          BULLET_SIZE  = 8,
  parameter logic [11:0] BULLET_COLOR = 12'hF00,
  parameter logic [11:0] TARGET_COLOR = 12'h0F0
) (
  input  logic          clk,
  input  logic          rst,
  draw_bullet_if.slave  vin,
  draw_bullet_if.master vout,
  input  logic [11:0]   bullet_x_in,
  input  logic [11:0]   bullet_y_in,
  input  logic          bullet_active_in,
  output logic          hit_out
);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        h_sync;
    logic        v_sync;
    logic        h_blank;
    logic        v_blank;
    logic [11:0] rgb;
  } pix_t;

  localparam logic [12:0] SIZE = 13'(BULLET_SIZE);

  pix_t        pix_in;
  pix_t        s1;
  pix_t        s2;
  logic        box_s1;
  logic [11:0] x_l;
  logic [11:0] y_l;
  logic        act_l;
  logic        hit_flag;

  logic        frame_start;
  logic        act_eff;
  logic [12:0] x_lo;
  logic [12:0] x_hi;
  logic [12:0] y_lo;
  logic [12:0] y_hi;
  logic [12:0] h13;
  logic [12:0] v13;
  logic        in_x;
  logic        in_y;
  logic        in_box;
  logic        hit_now;

  always_comb begin
    pix_in         = '0;
    pix_in.hcount  = vin.hcount;
    pix_in.vcount  = vin.vcount;
    pix_in.h_sync  = vin.h_sync;
    pix_in.v_sync  = vin.v_sync;
    pix_in.h_blank = vin.h_blank;
    pix_in.v_blank = vin.v_blank;
    pix_in.rgb     = vin.rgb;
  end

  // Pixel (0,0) already uses the position being latched for its frame.
  assign frame_start = (vin.hcount == 11'd0)
                    && (vin.vcount == 11'd0);
  assign act_eff = frame_start ? bullet_active_in : act_l;
  assign x_lo = {1'b0, frame_start ? bullet_x_in : x_l};
  assign y_lo = {1'b0, frame_start ? bullet_y_in : y_l};
  assign x_hi = x_lo + SIZE;
  assign y_hi = y_lo + SIZE;
  assign h13  = {2'b00, vin.hcount};
  assign v13  = {2'b00, vin.vcount};

  assign in_x = (h13 >= x_lo) && (h13 < x_hi);
  assign in_y = (v13 >= y_lo) && (v13 < y_hi);

  assign in_box = act_eff
               && !vin.h_blank
               && !vin.v_blank
               && in_x
               && in_y;

  assign hit_now = box_s1
                && (s1.rgb == TARGET_COLOR);

  always_ff @(posedge clk) begin
    if (rst) begin
      x_l      <= '0;
      y_l      <= '0;
      act_l    <= 1'b0;
      s1       <= '0;
      box_s1   <= 1'b0;
      s2       <= '0;
      hit_flag <= 1'b0;
      hit_out  <= 1'b0;
    end else begin
      if (frame_start) begin
        x_l   <= bullet_x_in;
        y_l   <= bullet_y_in;
        act_l <= bullet_active_in;
      end
      s1     <= pix_in;
      box_s1 <= in_box;
      s2     <= s1;
      if (box_s1)
        s2.rgb <= BULLET_COLOR;
      // An overlap still in flight at the latch edge closes out the old frame.
      hit_out  <= frame_start
               && (hit_flag || hit_now);
      hit_flag <= !frame_start
               && (hit_flag || hit_now);
    end
  end

  assign vout.hcount  = s2.hcount;
  assign vout.vcount  = s2.vcount;
  assign vout.h_sync  = s2.h_sync;
  assign vout.v_sync  = s2.v_sync;
  assign vout.h_blank = s2.h_blank;
  assign vout.v_blank = s2.v_blank;
  assign vout.rgb     = s2.rgb;

endmodule

// File: tb/tb_draw_bullet.sv
// Scoreboard bench for draw_bullet: random frames vs a frame-level model.
// Expected pixels and hit pulses are queued by the driver and popped by a monitor.
module tb_draw_bullet;
  localparam int          S  = 8;
  localparam logic [11:0] BC = 12'hF00;
  localparam logic [11:0] TC = 12'h0F0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_q = 1'b1;
  logic [11:0] bx = '0;
  logic [11:0] by = '0;
  logic        ba = 1'b0;
  logic        hit;

  always #5 clk = ~clk;

  draw_bullet_if vin();
  draw_bullet_if vout();

  draw_bullet #(
    .BULLET_SIZE(S),
    .BULLET_COLOR(BC),
    .TARGET_COLOR(TC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vin(vin),
    .vout(vout),
    .bullet_x_in(bx),
    .bullet_y_in(by),
    .bullet_active_in(ba),
    .hit_out(hit)
  );

  typedef struct {
    int          h;
    int          v;
    bit          hs;
    bit          vs;
    bit          hb;
    bit          vb;
    logic [11:0] rgb;
  } exp_t;

  exp_t pq[$];
  bit   hq[$];
  int   checks = 0;
  int   errors = 0;

  // frame-level model state
  int fx = 0;
  int fy = 0;
  bit fa = 0;
  bit pend = 0;
  bit fixed_bg = 0;
  logic [11:0] bg_col = 12'h00F;

  function automatic logic [11:0] bg();
    logic [11:0] c;
    if (fixed_bg) return bg_col;
    c = 12'($urandom);
    if (c == TC) c = 12'h00F;
    return c;
  endfunction

  task automatic put(input int h, input int v,
                     input logic [11:0] c,
                     input int nx, input int ny, input bit na);
    exp_t e;
    bit   box;
    @(posedge clk);
    #1;
    vin.hcount  = 11'(h);
    vin.vcount  = 11'(v);
    vin.h_sync  = (h >= 840 && h < 968);
    vin.v_sync  = (v >= 601 && v < 605);
    vin.h_blank = (h >= 800);
    vin.v_blank = (v >= 600);
    vin.rgb     = c;
    bx = 12'(nx);
    by = 12'(ny);
    ba = na;
    if (h == 0 && v == 0) begin
      fx = nx;
      fy = ny;
      fa = na;
      hq.push_back(pend);
      pend = 0;
    end else begin
      hq.push_back(1'b0);
    end
    box = fa && h < 800 && v < 600
       && h >= fx && h < fx + S
       && v >= fy && v < fy + S;
    if (box && c == TC) pend = 1;
    e.h   = h;
    e.v   = v;
    e.hs  = (h >= 840 && h < 968);
    e.vs  = (v >= 601 && v < 605);
    e.hb  = (h >= 800);
    e.vb  = (v >= 600);
    e.rgb = box ? BC : c;
    pq.push_back(e);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    pq.delete();
    hq.delete();
    fa = 0;
    pend = 0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One frame: (0,0) latch pixel with (x,y,a), optional rows near the
  // origin, then a window; mid-frame bullet inputs carry (nx,ny,na).
  task automatic frame(input int x, input int y, input bit a,
                       input int hlo, input int hhi,
                       input int vlo, input int vhi,
                       input int tv, input int thlo, input int thhi,
                       input bit low, input bit rtgt,
                       input int nx, input int ny, input bit na);
    logic [11:0] c;
    put(0, 0, bg(), x, y, a);
    if (low)
      for (int v = 0; v < 4; v++)
        for (int h = 1; h < 6; h++)
          put(h, v, bg(), nx, ny, na);
    for (int v = vlo; v <= vhi; v++)
      for (int h = hlo; h <= hhi; h++) begin
        if (v == tv && h >= thlo && h <= thhi)
          c = TC;
        else if (rtgt && $urandom_range(3) == 0)
          c = TC;
        else
          c = bg();
        put(h, v, c, nx, ny, na);
      end
  endtask

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    exp_t e;
    bit   eh;
    if (rst_q) begin
      checks++;
      if (vout.hcount !== 0 || vout.vcount !== 0 ||
          vout.h_sync !== 0 || vout.v_sync !== 0 ||
          vout.h_blank !== 0 || vout.v_blank !== 0 ||
          vout.rgb !== 0 || hit !== 0) begin
        errors++;
        $display("FAIL reset_zero got hc=%0d vc=%0d rgb=%h hit=%b exp all 0",
                 vout.hcount, vout.vcount, vout.rgb, hit);
      end
    end else if (!rst) begin
      if (pq.size() == 3) begin
        e = pq.pop_front();
        checks++;
        if (vout.hcount !== 11'(e.h) || vout.vcount !== 11'(e.v) ||
            vout.h_sync !== e.hs || vout.v_sync !== e.vs ||
            vout.h_blank !== e.hb || vout.v_blank !== e.vb ||
            vout.rgb !== e.rgb) begin
          errors++;
          $display("FAIL pix got h=%0d v=%0d sync=%b%b blank=%b%b rgb=%h exp h=%0d v=%0d sync=%b%b blank=%b%b rgb=%h",
                   vout.hcount, vout.vcount, vout.h_sync, vout.v_sync,
                   vout.h_blank, vout.v_blank, vout.rgb,
                   e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.rgb);
        end
      end
      if (hq.size() == 2) begin
        eh = hq.pop_front();
        checks++;
        if (hit !== eh) begin
          errors++;
          $display("FAIL hit_out at t=%0t got %b exp %b", $time, hit, eh);
        end
      end
    end
  end

  int rx[22];
  int ry[22];
  bit ra[22];

  initial begin
    vin.hcount = '0;
    vin.vcount = '0;
    vin.h_sync = 1'b0;
    vin.v_sync = 1'b0;
    vin.h_blank = 1'b0;
    vin.v_blank = 1'b0;
    vin.rgb = '0;
    vin.hcount = 11'd500;
    do_reset(3);

    // basic draw on a fixed background, then a target overlap
    fixed_bg = 1;
    frame(100, 50, 1, 96, 112, 48, 60, -1, 0, 0, 0, 0, 100, 50, 1);
    frame(100, 50, 1, 96, 112, 48, 60, 52, 104, 110, 0, 0, 100, 50, 1);
    frame(100, 50, 1, 96, 112, 48, 60, -1, 0, 0, 0, 0, 100, 50, 1);
    fixed_bg = 0;

    // move mid-frame: stays at 100 this frame, 300 next
    put(0, 0, bg(), 100, 50, 1);
    for (int v = 48; v <= 60; v++)
      for (int h = 96; h <= 112; h++)
        put(h, v, bg(), v >= 52 ? 300 : 100, 50, 1);
    for (int v = 48; v <= 60; v++)
      for (int h = 296; h <= 312; h++)
        put(h, v, bg(), 300, 50, 1);
    frame(300, 50, 1, 94, 312, 49, 58, -1, 0, 0, 0, 0, 300, 50, 1);

    // screen-edge clipping, no wrap into the origin rows
    frame(796, 596, 1, 790, 805, 592, 605, 598, 797, 803, 1, 0, 796, 596, 1);
    frame(796, 596, 1, 790, 805, 592, 605, -1, 0, 0, 1, 0, 796, 596, 1);

    // inactive bullet over a target region
    frame(100, 50, 0, 96, 112, 48, 60, 52, 96, 112, 0, 0, 100, 50, 0);
    frame(100, 50, 0, 96, 112, 48, 60, -1, 0, 0, 0, 0, 100, 50, 1);

    // reset mid-frame with a pending hit
    put(0, 0, bg(), 100, 50, 1);
    for (int v = 48; v <= 53; v++)
      for (int h = 96; h <= 112; h++)
        put(h, v, (v == 52) ? TC : bg(), 100, 50, 1);
    do_reset(3);
    for (int v = 54; v <= 60; v++)
      for (int h = 96; h <= 112; h++)
        put(h, v, (v == 55) ? TC : bg(), 100, 50, 1);
    frame(100, 50, 1, 96, 112, 48, 60, 53, 90, 110, 0, 0, 100, 50, 1);
    frame(100, 50, 1, 96, 112, 48, 60, -1, 0, 0, 0, 0, 0, 0, 1);

    // bullet at the origin, overlap on the latch pixel's frame
    frame(0, 0, 1, 0, 12, 1, 10, 3, 0, 12, 1, 0, 0, 0, 1);

    // randomized frames
    for (int i = 0; i < 22; i++) begin
      rx[i] = $urandom_range(0, 810);
      ry[i] = $urandom_range(0, 610);
      ra[i] = ($urandom_range(3) != 0);
    end
    for (int i = 0; i < 21; i++)
      frame(rx[i], ry[i], ra[i],
            rx[i] < 5 ? 0 : rx[i] - 5, rx[i] + S + 4,
            ry[i] < 5 ? 1 : ry[i] - 5, ry[i] + S + 4,
            -1, 0, 0, $urandom_range(1), 1,
            rx[i + 1], ry[i + 1], ra[i + 1]);
    put(0, 0, bg(), 0, 0, 0);
    repeat (3) put(1000, 700, bg(), 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
